keypad_number_entry: RTL and testbench
======================================

Name: keypad_number_entry

Overview:
- Upstream of the two-digit decimal splitter; builds a 0–99 value from decoded PmodKYPD key codes.
- Debounces `key_pressed`, accepts exactly one action per physical press, and edits a pending entry with digit, clear, backspace and enter keys.
- `number` holds the last committed value and feeds the decimal splitter directly. `entry` is available for live display of the value being typed.

Parameters:
- DEBOUNCE_CYCLES, 100000, number of consecutive identical samples needed to accept a press or a release (1 ms at 100 MHz); legal range ≥1.
- CNT_W, 17, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- key_code  input  4  decoded key; 0x0–0x9 digits, 0xA clear, 0xB backspace, 0xE enter; 0xC, 0xD, 0xF are ignored.
- key_pressed  input  1  high while any key is held; synchronous to clk; may bounce.
- number  output  8  last committed value, 0–99.
- entry  output  8  pending value being typed, 0–99.
- digit_count  output  2  digits in entry, 0–2.
- commit  output  1  one-cycle pulse when number is updated.
- reject  output  1  one-cycle pulse when a digit key arrives with digit_count==2.

Behaviour:
- Reset: all outputs 0, FSM IDLE, debounce counter 0, latched code 0. rst overrides every other input on the same edge.
- Reset mid-press: the press is abandoned with no action. After reset, the FSM returns to IDLE, so a key still held when rst deasserts is accepted after DEBOUNCE_CYCLES samples.
- FSM states: IDLE, DEB_P, HELD, DEB_R.
- IDLE:
  - key_pressed=1 → latch key_code, cnt=1.
  - If DEBOUNCE_CYCLES==1, perform the action on this edge and go to HELD; otherwise go to DEB_P.
- DEB_P:
  - key_pressed=0 → IDLE, no action.
  - key_code ≠ latched → re-latch key_code, cnt=1, stay in DEB_P.
  - Otherwise cnt++. On the edge where cnt reaches DEBOUNCE_CYCLES, perform the action and go to HELD.
- HELD: stay while key_pressed=1 (no auto-repeat). key_pressed=0 → cnt=1; if DEBOUNCE_CYCLES==1 go to IDLE, else go to DEB_R.
- DEB_R: key_pressed=1 → HELD. Otherwise cnt++; on the edge where cnt reaches DEBOUNCE_CYCLES, go to IDLE.
- Action latency: the action is applied on the same edge as acceptance. Updated entry, number and pulses are visible in the following cycle. commit and reject are high for exactly one cycle and 0 otherwise.
- Digit action (0–9):
  - digit_count<2: entry ← entry×10 + code (8-bit result; max 99, no overflow possible); digit_count++.
  - digit_count==2: entry unchanged, reject=1.
- 0xA (clear): entry ← 0, digit_count ← 0; number unchanged.
- 0xB (backspace): digit_count>0 → entry ← entry/10 (integer), digit_count−−. digit_count==0 → no-op.
- 0xE (enter):
  - digit_count>0: number ← entry, commit=1, entry ← 0, digit_count ← 0.
  - digit_count==0: no-op, no commit; number is kept.
- 0xC, 0xD, 0xF: no state change beyond the FSM; no pulses.
- Leading zero counts as a digit: "0","7" gives entry=7, digit_count=2.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4; "press" means key_pressed high for ≥4 cycles, followed by ≥4 cycles low.
1. Press 4, press 2, press E → entry 4 then 42; commit high one cycle; number=42; entry=0, digit_count=0.
2. key_pressed high 3 cycles with code 7, then low → no change. A code change 5→6 on cycle 2 of 4, held 4 more cycles → digit 6 accepted once.
3. Press 9, 9, 5 → entry=99, digit_count=2; reject pulses one cycle on the 5; then E → number=99.
4. Press 3, 8, B → entry=3, digit_count=1; press B, B → entry=0, digit_count=0, no pulses; press E → no commit, number unchanged.
5. Hold 5 for 50 cycles; release bounce (low 2, high 1, low 4) → exactly one digit accepted, entry=5.
6. Type 6, then assert rst during DEB_P of the next key → all outputs 0 the next cycle, no action from the abandoned press; press A then E → number stays 0, no commit.

Source files
------------

// File: rtl/keypad_number_entry.sv
// Debounced keypad front end that builds a 0-99 value from decoded key codes.
// Digit, clear, backspace and enter edit a pending entry; enter commits it to number.
module keypad_number_entry #(
    parameter int unsigned DEBOUNCE_CYCLES = 100000,
    parameter int unsigned CNT_W           = 17
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] key_code,
    input  logic       key_pressed,
    output logic [7:0] number,
    output logic [7:0] entry,
    output logic [1:0] digit_count,
    output logic       commit,
    output logic       reject
);

    localparam int unsigned VAL_W = 8;
    localparam logic [3:0] KEY_CLEAR = 4'hA;
    localparam logic [3:0] KEY_BACK  = 4'hB;
    localparam logic [3:0] KEY_ENTER = 4'hE;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DEB_P = 2'd1,
        HELD  = 2'd2,
        DEB_R = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         code_q, code_d;
    logic [VAL_W-1:0]   number_q, number_d;
    logic [VAL_W-1:0]   entry_q, entry_d;
    logic [1:0]         dcount_q, dcount_d;
    logic               commit_q, commit_d;
    logic               reject_q, reject_d;

    logic               act_c;
    logic [3:0]         act_code_c;
    logic [CNT_W-1:0]   cnt_inc_c;
    logic               cnt_done_c;

    assign cnt_inc_c  = cnt_q + CNT_W'(1);
    assign cnt_done_c = (cnt_inc_c == CNT_W'(DEBOUNCE_CYCLES));

    // Debounce FSM, then the key action on the acceptance edge
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        code_d     = code_q;
        number_d   = number_q;
        entry_d    = entry_q;
        dcount_d   = dcount_q;
        commit_d   = 1'b0;
        reject_d   = 1'b0;
        act_c      = 1'b0;
        act_code_c = code_q;

        unique case (state_q)
            IDLE: begin
                if (key_pressed) begin
                    code_d = key_code;
                    cnt_d  = CNT_W'(1);
                    if (DEBOUNCE_CYCLES == 1) begin
                        act_c      = 1'b1;
                        act_code_c = key_code;
                        state_d    = HELD;
                    end else begin
                        state_d = DEB_P;
                    end
                end
            end
            DEB_P: begin
                if (!key_pressed) begin
                    state_d = IDLE;
                end else if (key_code != code_q) begin
                    code_d = key_code;
                    cnt_d  = CNT_W'(1);
                end else begin
                    cnt_d = cnt_inc_c;
                    if (cnt_done_c) begin
                        act_c   = 1'b1;
                        state_d = HELD;
                    end
                end
            end
            HELD: begin
                if (!key_pressed) begin
                    cnt_d   = CNT_W'(1);
                    state_d = (DEBOUNCE_CYCLES == 1) ? IDLE : DEB_R;
                end
            end
            DEB_R: begin
                if (key_pressed) begin
                    state_d = HELD;
                end else begin
                    cnt_d = cnt_inc_c;
                    if (cnt_done_c) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (act_c) begin
            if (act_code_c <= 4'd9) begin
                if (dcount_q < 2'd2) begin
                    entry_d  = VAL_W'(entry_q * VAL_W'(10)) + VAL_W'(act_code_c);
                    dcount_d = dcount_q + 2'd1;
                end else begin
                    reject_d = 1'b1;
                end
            end else if (act_code_c == KEY_CLEAR) begin
                entry_d  = '0;
                dcount_d = '0;
            end else if (act_code_c == KEY_BACK) begin
                if (dcount_q != 2'd0) begin
                    entry_d  = entry_q / VAL_W'(10);
                    dcount_d = dcount_q - 2'd1;
                end
            end else if (act_code_c == KEY_ENTER) begin
                if (dcount_q != 2'd0) begin
                    number_d = entry_q;
                    commit_d = 1'b1;
                    entry_d  = '0;
                    dcount_d = '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            code_q   <= '0;
            number_q <= '0;
            entry_q  <= '0;
            dcount_q <= '0;
            commit_q <= 1'b0;
            reject_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            code_q   <= code_d;
            number_q <= number_d;
            entry_q  <= entry_d;
            dcount_q <= dcount_d;
            commit_q <= commit_d;
            reject_q <= reject_d;
        end
    end

    assign number      = number_q;
    assign entry       = entry_q;
    assign digit_count = dcount_q;
    assign commit      = commit_q;
    assign reject      = reject_q;

endmodule

// File: tb/tb_keypad_number_entry.sv
// Directed bench for keypad_number_entry with a short debounce window.
module tb_keypad_number_entry;

    localparam int unsigned DEB = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] key_code;
    logic       key_pressed;
    logic [7:0] number;
    logic [7:0] entry;
    logic [1:0] digit_count;
    logic       commit;
    logic       reject;

    int total  = 0;
    int passed = 0;
    int n_commit;
    int n_reject;

    keypad_number_entry #(
        .DEBOUNCE_CYCLES(DEB),
        .CNT_W          (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key_code   (key_code),
        .key_pressed(key_pressed),
        .number     (number),
        .entry      (entry),
        .digit_count(digit_count),
        .commit     (commit),
        .reject     (reject)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // One clock; sample 1 time unit after the edge and tally pulses
    task automatic tick();
        @(posedge clk);
        #1;
        if (commit === 1'b1) n_commit++;
        if (reject === 1'b1) n_reject++;
    endtask

    task automatic hold(input logic kp, input logic [3:0] code, input int n);
        key_pressed = kp;
        key_code    = code;
        repeat (n) tick();
    endtask

    task automatic press(input logic [3:0] code);
        n_commit = 0;
        n_reject = 0;
        hold(1'b1, code, DEB + 2);
        hold(1'b0, code, DEB + 1);
    endtask

    initial begin
        rst         = 1'b1;
        key_code    = 4'h0;
        key_pressed = 1'b0;
        n_commit    = 0;
        n_reject    = 0;
        repeat (2) tick();
        chk("reset_number", number, 8'd0);
        chk("reset_entry", entry, 8'd0);
        chk("reset_dcount", 8'(digit_count), 8'd0);
        chk("reset_pulses", 8'({commit, reject}), 8'd0);
        rst = 1'b0;
        tick();

        // Scenario 1: 4, 2, enter
        press(4'h4);
        chk("s1_entry4", entry, 8'd4);
        chk("s1_dcount1", 8'(digit_count), 8'd1);
        press(4'h2);
        chk("s1_entry42", entry, 8'd42);
        n_commit = 0;
        hold(1'b1, 4'hE, DEB - 1);
        chk("s1_commit_before", 8'(commit), 8'd0);
        tick();
        chk("s1_commit_edge", 8'(commit), 8'd1);
        chk("s1_number42", number, 8'd42);
        tick();
        chk("s1_commit_drop", 8'(commit), 8'd0);
        hold(1'b0, 4'hE, DEB + 1);
        chk("s1_commit_count", 8'(n_commit), 8'd1);
        chk("s1_entry0", entry, 8'd0);
        chk("s1_dcount0", 8'(digit_count), 8'd0);

        // Scenario 2: short glitch, then code change mid-debounce
        hold(1'b1, 4'h7, DEB - 1);
        hold(1'b0, 4'h7, DEB + 1);
        chk("s2_glitch_entry", entry, 8'd0);
        chk("s2_glitch_dcount", 8'(digit_count), 8'd0);
        hold(1'b1, 4'h5, 1);
        hold(1'b1, 4'h6, DEB - 1);
        chk("s2_not_yet", 8'(digit_count), 8'd0);
        hold(1'b1, 4'h6, 1);
        chk("s2_entry6", entry, 8'd6);
        hold(1'b1, 4'h6, 3);
        hold(1'b0, 4'h6, DEB + 1);
        chk("s2_once", 8'(digit_count), 8'd1);

        // Scenario 3: 99 then rejected 5, then enter
        press(4'hA);
        chk("s3_clear", entry, 8'd0);
        press(4'h9);
        press(4'h9);
        chk("s3_entry99", entry, 8'd99);
        chk("s3_dcount2", 8'(digit_count), 8'd2);
        press(4'h5);
        chk("s3_reject_count", 8'(n_reject), 8'd1);
        chk("s3_entry_kept", entry, 8'd99);
        press(4'hE);
        chk("s3_number99", number, 8'd99);
        chk("s3_commit_count", 8'(n_commit), 8'd1);

        // Scenario 4: backspace and empty enter
        press(4'h3);
        press(4'h8);
        press(4'hB);
        chk("s4_entry3", entry, 8'd3);
        chk("s4_dcount1", 8'(digit_count), 8'd1);
        press(4'hB);
        press(4'hB);
        chk("s4_entry0", entry, 8'd0);
        chk("s4_dcount0", 8'(digit_count), 8'd0);
        chk("s4_no_pulses", 8'(n_commit + n_reject), 8'd0);
        press(4'hE);
        chk("s4_no_commit", 8'(n_commit), 8'd0);
        chk("s4_number_kept", number, 8'd99);

        // Scenario 5: long hold with release bounce
        hold(1'b1, 4'h5, 50);
        hold(1'b0, 4'h5, 2);
        hold(1'b1, 4'h5, 1);
        hold(1'b0, 4'h5, DEB);
        hold(1'b0, 4'h5, 2);
        chk("s5_entry5", entry, 8'd5);
        chk("s5_dcount1", 8'(digit_count), 8'd1);

        // Ignored key and leading zero
        press(4'hC);
        chk("ign_entry", entry, 8'd5);
        chk("ign_pulses", 8'(n_commit + n_reject), 8'd0);
        press(4'hA);
        press(4'h0);
        press(4'h7);
        chk("lz_entry7", entry, 8'd7);
        chk("lz_dcount2", 8'(digit_count), 8'd2);

        // Scenario 6: reset during debounce of a second key
        press(4'hA);
        press(4'h6);
        chk("s6_entry6", entry, 8'd6);
        hold(1'b1, 4'h3, 2);
        rst = 1'b1;
        tick();
        chk("s6_rst_number", number, 8'd0);
        chk("s6_rst_entry", entry, 8'd0);
        chk("s6_rst_dcount", 8'(digit_count), 8'd0);
        rst = 1'b0;
        hold(1'b0, 4'h3, DEB + 1);
        chk("s6_abandoned", entry, 8'd0);
        press(4'hA);
        press(4'hE);
        chk("s6_no_commit", 8'(n_commit), 8'd0);
        chk("s6_number0", number, 8'd0);

        // Key held across reset is accepted after a full debounce
        key_pressed = 1'b1;
        key_code    = 4'h8;
        rst         = 1'b1;
        tick();
        rst = 1'b0;
        hold(1'b1, 4'h8, DEB - 1);
        chk("rst_held_wait", 8'(digit_count), 8'd0);
        hold(1'b1, 4'h8, 1);
        chk("rst_held_entry8", entry, 8'd8);
        hold(1'b0, 4'h8, DEB + 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
